// File: rtl/agc_arith_pkg.sv
// Shared encodings for the arithmetic-unit slices: read-bus selects,
// write-strobe bit positions and G load modes.
package agc_arith_pkg;

  // Read-bus select codes
  typedef enum logic [2:0] {
    RD_NONE = 3'd0,
    RD_A    = 3'd1,
    RD_L    = 3'd2,
    RD_Q    = 3'd3,
    RD_Z    = 3'd4,
    RD_B    = 3'd5,
    RD_G    = 3'd6,
    RD_SUM  = 3'd7
  } rd_sel_e;

  // Bit positions inside the wr_en strobe vector
  localparam int WR_A     = 0;
  localparam int WR_L     = 1;
  localparam int WR_Q     = 2;
  localparam int WR_Z     = 3;
  localparam int WR_B     = 4;
  localparam int WR_G     = 5;
  localparam int WR_COUNT = 6;

  // G load modes; code 3 behaves like a straight load
  typedef enum logic [1:0] {
    G_STRAIGHT  = 2'd0,
    G_SHIFT_R   = 2'd1,
    G_CYCLE_L   = 2'd2,
    G_STRAIGHT3 = 2'd3
  } g_mode_e;

endpackage

// File: rtl/agc_slice_adder.sv
// WIDTH-bit unsigned adder with carry in and carry out. The ones'-complement
// end-around carry is closed by the parent through a register, never here.
module agc_slice_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  // Zero-extend all operands so the carry lands in the extra bit
  assign {co, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};

endmodule

// File: rtl/agc_arith_slice.sv
// One WIDTH-bit slice of the central registers, adder input registers,
// slice adder, read-bus mux and G shifter. The top-of-word instance also
// carries the sticky overflow latch and the end-around-carry register.
module agc_arith_slice
  import agc_arith_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit IS_TOP = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    wl_in,
  input  logic                wl_lo_in,
  input  logic                wl_hi_in,
  input  logic [WR_COUNT-1:0] wr_en,
  input  logic                wr_src,
  input  logic [1:0]          g_mode,
  input  logic                x_load,
  input  logic                y_load,
  input  logic                clr_xy,
  input  logic                ci,
  input  logic                eac_cap,
  input  logic                ovf_clr,
  input  logic [2:0]          rd_sel,
  output logic [WIDTH-1:0]    rd_out,
  output logic [WIDTH-1:0]    sum,
  output logic                co,
  output logic                g_par,
  output logic                eac_q,
  output logic                ovf_pos,
  output logic                ovf_neg
);

  logic [WIDTH-1:0] a_q, l_q, q_q, z_q, b_q, g_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] g_next;

  agc_slice_adder #(.WIDTH(WIDTH)) u_adder (
    .x  (x_q),
    .y  (y_q),
    .ci (ci),
    .sum(sum),
    .co (co)
  );

  assign wr_data = wr_src ? sum : wl_in;

  // G load value: straight, shift right with fill from above, or cycle left with fill from below
  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    g_next = wr_data;
    case (g_mode_e'(g_mode))
      G_SHIFT_R: g_next = {wl_hi_in, wr_data[WIDTH-1:1]};
      G_CYCLE_L: g_next = {wr_data[WIDTH-2:0], wl_lo_in};
      default:   g_next = wr_data;
    endcase
  end

  // Central registers load the shared write data under their own strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      l_q <= '0;
      q_q <= '0;
      z_q <= '0;
      b_q <= '0;
      g_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (wr_en[WR_A]) a_q <= wr_data;
      if (wr_en[WR_L]) l_q <= wr_data;
      if (wr_en[WR_Q]) q_q <= wr_data;
      if (wr_en[WR_Z]) z_q <= wr_data;
      if (wr_en[WR_B]) b_q <= wr_data;
      if (wr_en[WR_G]) g_q <= g_next;
    end
  end

  // Adder inputs: a load beats a clear, so clear-then-write fits in one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      if (x_load)      x_q <= wl_in;
      else if (clr_xy) x_q <= '0;
      if (y_load)      y_q <= wl_in;
      else if (clr_xy) y_q <= '0;
    end
  end

  // Read-bus mux from current state
  always_comb begin
    rd_out = '0;
    case (rd_sel_e'(rd_sel))
      RD_A:    rd_out = a_q;
      RD_L:    rd_out = l_q;
      RD_Q:    rd_out = q_q;
      RD_Z:    rd_out = z_q;
      RD_B:    rd_out = b_q;
      RD_G:    rd_out = g_q;
      RD_SUM:  rd_out = sum;
      default: rd_out = '0;
    endcase
  end

  assign g_par = ^g_q;

  generate
    if (IS_TOP) begin : g_top
      logic eac_r, ovf_pos_r, ovf_neg_r;
      logic set_pos, set_neg;

      // The two sign bits of a sum written into A disagree on overflow
      assign set_pos = wr_en[WR_A] & wr_src & (sum[WIDTH-1:WIDTH-2] == 2'b01);
      assign set_neg = wr_en[WR_A] & wr_src & (sum[WIDTH-1:WIDTH-2] == 2'b10);

      // End-around carry capture and sticky overflow flags; a set beats a clear
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          eac_r     <= 1'b0;
          ovf_pos_r <= 1'b0;
          ovf_neg_r <= 1'b0;
        end else begin
          if (eac_cap)     eac_r <= co;
          else if (clr_xy) eac_r <= 1'b0;
          if (set_pos)      ovf_pos_r <= 1'b1;
          else if (ovf_clr) ovf_pos_r <= 1'b0;
          if (set_neg)      ovf_neg_r <= 1'b1;
          else if (ovf_clr) ovf_neg_r <= 1'b0;
        end
      end

      assign eac_q   = eac_r;
      assign ovf_pos = ovf_pos_r;
      assign ovf_neg = ovf_neg_r;
    end else begin : g_mid
      // Lower slices ignore the top-only controls
      logic unused_top_ctrl;
      assign unused_top_ctrl = eac_cap ^ ovf_clr;
      assign eac_q   = 1'b0;
      assign ovf_pos = 1'b0;
      assign ovf_neg = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_agc_arith_slice.sv
// Scoreboard bench for the top-of-word slice: expected values are queued as
// stimulus is driven and popped against the observed outputs.
module tb_agc_arith_slice;
  import agc_arith_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] wl_in;
  logic         wl_lo_in, wl_hi_in;
  logic [5:0]   wr_en;
  logic         wr_src;
  logic [1:0]   g_mode;
  logic         x_load, y_load, clr_xy, ci, eac_cap, ovf_clr;
  logic [2:0]   rd_sel;
  logic [W-1:0] rd_out, sum;
  logic         co, g_par, eac_q, ovf_pos, ovf_neg;

  typedef struct {
    string      name;
    logic [W:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [W:0] obs[$];
  int         n_cmp = 0;
  int         n_err = 0;

  agc_arith_slice #(.WIDTH(W), .IS_TOP(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .wl_in   (wl_in),
    .wl_lo_in(wl_lo_in),
    .wl_hi_in(wl_hi_in),
    .wr_en   (wr_en),
    .wr_src  (wr_src),
    .g_mode  (g_mode),
    .x_load  (x_load),
    .y_load  (y_load),
    .clr_xy  (clr_xy),
    .ci      (ci),
    .eac_cap (eac_cap),
    .ovf_clr (ovf_clr),
    .rd_sel  (rd_sel),
    .rd_out  (rd_out),
    .sum     (sum),
    .co      (co),
    .g_par   (g_par),
    .eac_q   (eac_q),
    .ovf_pos (ovf_pos),
    .ovf_neg (ovf_neg)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wl_in = '0; wl_lo_in = 1'b0; wl_hi_in = 1'b0; wr_en = '0; wr_src = 1'b0;
    g_mode = 2'd0; x_load = 1'b0; y_load = 1'b0; clr_xy = 1'b0; ci = 1'b0;
    eac_cap = 1'b0; ovf_clr = 1'b0; rd_sel = RD_NONE;
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled at +1
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input logic [W:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      #1;
      expect_val($sformatf("reset_rd_out_sel%0d", s), '0);
      obs.push_back({1'b0, rd_out});
    end
    expect_val("reset_sum", '0);    obs.push_back({1'b0, sum});
    expect_val("reset_co", '0);     obs.push_back({4'b0, co});
    expect_val("reset_g_par", '0);  obs.push_back({4'b0, g_par});
    expect_val("reset_eac_q", '0);  obs.push_back({4'b0, eac_q});
    expect_val("reset_ovf_pos", '0); obs.push_back({4'b0, ovf_pos});
    expect_val("reset_ovf_neg", '0); obs.push_back({4'b0, ovf_neg});
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [W:0] o = obs.pop_front();
      n_cmp++;
      if (o !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_write();
    idle();
    wl_in = 4'hA;
    wr_en = (6'd1 << WR_A) | (6'd1 << WR_Q);
    expect_val("write_a", 5'h0A);
    expect_val("write_q", 5'h0A);
    expect_val("write_l_untouched", 5'h00);
    expect_val("write_g_par", 5'h00);
    step();
    idle();
    rd_sel = RD_A; #1; obs.push_back({1'b0, rd_out});
    rd_sel = RD_Q; #1; obs.push_back({1'b0, rd_out});
    rd_sel = RD_L; #1; obs.push_back({1'b0, rd_out});
    obs.push_back({4'b0, g_par});
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [W:0] o = obs.pop_front();
      n_cmp++;
      if (o !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_adder_eac();
    idle(); x_load = 1'b1; wl_in = 4'h9; step();
    idle(); y_load = 1'b1; wl_in = 4'h8; step();
    idle();
    ci = 1'b0; #1;
    expect_val("add_ci0_sum", 5'h01); obs.push_back({1'b0, sum});
    expect_val("add_ci0_co", 5'h01);  obs.push_back({4'b0, co});
    ci = 1'b1; rd_sel = RD_SUM; #1;
    expect_val("add_ci1_sum", 5'h02);  obs.push_back({1'b0, sum});
    expect_val("add_ci1_co", 5'h01);   obs.push_back({4'b0, co});
    expect_val("add_rd_sum", 5'h02);   obs.push_back({1'b0, rd_out});
    expect_val("eac_before_cap", 5'h00); obs.push_back({4'b0, eac_q});
    eac_cap = 1'b1;
    step();
    idle(); #1;
    expect_val("eac_captured", 5'h01); obs.push_back({4'b0, eac_q});
    step(); #1;
    expect_val("eac_holds", 5'h01);    obs.push_back({4'b0, eac_q});
    clr_xy = 1'b1;
    step();
    idle(); #1;
    expect_val("eac_cleared", 5'h00);  obs.push_back({4'b0, eac_q});
    expect_val("clr_sum", 5'h00);      obs.push_back({1'b0, sum});
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [W:0] o = obs.pop_front();
      n_cmp++;
      if (o !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_g_shift();
    idle(); wr_en = 6'd1 << WR_G; g_mode = 2'd1; wl_in = 4'b0110; wl_hi_in = 1'b1;
    step();
    idle(); rd_sel = RD_G; #1;
    expect_val("g_shift_right", 5'b01011); obs.push_back({1'b0, rd_out});
    expect_val("g_par_sr", 5'h01);         obs.push_back({4'b0, g_par});
    wr_en = 6'd1 << WR_G; g_mode = 2'd2; wl_in = 4'b0110; wl_lo_in = 1'b1;
    step();
    idle(); rd_sel = RD_G; #1;
    expect_val("g_cycle_left", 5'b01101);  obs.push_back({1'b0, rd_out});
    wr_en = 6'd1 << WR_G; g_mode = 2'd3; wl_in = 4'b0110; wl_lo_in = 1'b1; wl_hi_in = 1'b1;
    step();
    idle(); rd_sel = RD_G; #1;
    expect_val("g_straight3", 5'b00110);   obs.push_back({1'b0, rd_out});
    expect_val("g_par_even", 5'h00);       obs.push_back({4'b0, g_par});
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [W:0] o = obs.pop_front();
      n_cmp++;
      if (o !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_overflow();
    idle(); x_load = 1'b1; y_load = 1'b1; wl_in = 4'b0100; step();
    idle(); wr_en = 6'd1 << WR_A; wr_src = 1'b1; step();
    idle(); rd_sel = RD_A; #1;
    expect_val("ovf_a_sum", 5'b01000); obs.push_back({1'b0, rd_out});
    expect_val("ovf_neg_set", 5'h01);  obs.push_back({4'b0, ovf_neg});
    expect_val("ovf_pos_clear", 5'h00); obs.push_back({4'b0, ovf_pos});
    repeat (3) step();
    expect_val("ovf_neg_sticky", 5'h01); obs.push_back({4'b0, ovf_neg});
    ovf_clr = 1'b1; wr_en = 6'd1 << WR_A; wr_src = 1'b1; step();
    idle(); #1;
    expect_val("ovf_set_beats_clr", 5'h01); obs.push_back({4'b0, ovf_neg});
    ovf_clr = 1'b1; step();
    idle(); #1;
    expect_val("ovf_neg_cleared", 5'h00); obs.push_back({4'b0, ovf_neg});
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [W:0] o = obs.pop_front();
      n_cmp++;
      if (o !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_clr_xy();
    idle(); x_load = 1'b1; wl_in = 4'hF; step();
    idle(); y_load = 1'b1; wl_in = 4'h3; step();
    idle(); clr_xy = 1'b1; x_load = 1'b1; wl_in = 4'h5; step();
    idle(); #1;
    expect_val("clr_load_wins_sum", 5'h05); obs.push_back({1'b0, sum});
    expect_val("clr_load_wins_co", 5'h00);  obs.push_back({4'b0, co});
    clr_xy = 1'b1; step();
    idle(); ci = 1'b1; #1;
    expect_val("clr_alone_sum", 5'h01); obs.push_back({1'b0, sum});
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [W:0] o = obs.pop_front();
      n_cmp++;
      if (o !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] mdl[6];
    for (int r = 0; r < 6; r++) mdl[r] = '0;
    idle(); wr_en = 6'h3F; step();
    for (int i = 0; i < 24; i++) begin
      int           widx = $urandom_range(0, 5);
      int           ridx = $urandom_range(0, 5);
      logic [W-1:0] v = W'($urandom);
      idle();
      wl_in = v;
      wr_en = 6'd1 << widx;
      rd_sel = 3'(ridx + 1);
      #1;
      expect_val($sformatf("b2b_read%0d_reg%0d", i, ridx), {1'b0, mdl[ridx]});
      obs.push_back({1'b0, rd_out});
      mdl[widx] = v;
      step();
    end
    idle();
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [W:0] o = obs.pop_front();
      n_cmp++;
      if (o !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_async_reset();
    idle(); x_load = 1'b1; y_load = 1'b1; wl_in = 4'b0011; step();
    idle(); wr_en = 6'd1 << WR_A; wr_src = 1'b1; step();
    idle(); x_load = 1'b1; wl_in = 4'hF; step();
    idle(); rd_sel = RD_SUM; #1;
    expect_val("pre_rst_ovf_pos", 5'h01); obs.push_back({4'b0, ovf_pos});
    expect_val("pre_rst_sum", 5'h02);     obs.push_back({1'b0, sum});
    rst = 1'b0;
    #1;
    expect_val("arst_rd_sum", 5'h00); obs.push_back({1'b0, rd_out});
    expect_val("arst_sum", 5'h00);    obs.push_back({1'b0, sum});
    expect_val("arst_co", 5'h00);     obs.push_back({4'b0, co});
    expect_val("arst_ovf_pos", 5'h00); obs.push_back({4'b0, ovf_pos});
    expect_val("arst_ovf_neg", 5'h00); obs.push_back({4'b0, ovf_neg});
    expect_val("arst_eac_q", 5'h00);  obs.push_back({4'b0, eac_q});
    expect_val("arst_g_par", 5'h00);  obs.push_back({4'b0, g_par});
    rd_sel = RD_A; #1;
    expect_val("arst_rd_a", 5'h00);   obs.push_back({1'b0, rd_out});
    @(negedge clk);
    rst = 1'b1;
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [W:0] o = obs.pop_front();
      n_cmp++;
      if (o !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_adder_eac();
    test_g_shift();
    test_overflow();
    test_clr_xy();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/agc_arith_slice.md
# agc_arith_slice

Parametrised clocked successor to the fixed four-bit arithmetic-unit module covering bits 13–16. One instance holds a WIDTH-bit slice of the central registers A, L, Q, Z, B, G and of the adder input registers X and Y. It also contains the slice adder, a read-bus mux, G shift modes and G parity. The top-of-word instance (IS_TOP=1) adds a sticky overflow latch and a registered end-around-carry (EAC) capture. Slices tile across the word inside the arithmetic-unit wrapper.

## Interface
Parameters:
- WIDTH, 4, bits held by this slice (2..16)
- IS_TOP, 0, 1 enables overflow latch and EAC register

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- wl_in  in  WIDTH  write-bus value for this slice
- wl_lo_in  in  1  write-bus bit just below the slice (cycle-left fill)
- wl_hi_in  in  1  write-bus bit just above the slice (shift-right fill)
- wr_en  in  6  write strobes, bit0..5 = A,L,Q,Z,B,G
- wr_src  in  1  0: registers load wl_in; 1: registers load sum
- g_mode  in  2  0 straight, 1 shift right, 2 cycle left, 3 straight
- x_load, y_load  in  1 each  load X / Y from wl_in
- clr_xy  in  1  clear X and Y
- ci  in  1  carry into slice LSB
- eac_cap  in  1  top only: capture co into eac_q
- ovf_clr  in  1  top only: clear overflow latch
- rd_sel  in  3  0 none, 1 A, 2 L, 3 Q, 4 Z, 5 B, 6 G, 7 sum
- rd_out  out  WIDTH  selected value, 0 when rd_sel=0
- sum  out  WIDTH  (X+Y+ci) mod 2^WIDTH, combinational
- co  out  1  carry out of slice MSB, combinational
- g_par  out  1  XOR of G bits
- eac_q  out  1  registered end-around carry (0 when IS_TOP=0)
- ovf_pos, ovf_neg  out  1 each  sticky overflow flags (0 when IS_TOP=0)

## Operation
- All registers and flags reset to 0. Outputs after reset: rd_out=0, sum=0, co=0, g_par=0, eac_q=0, ovf_pos=ovf_neg=0.
- Write data is d = wr_src ? sum : wl_in. Each register with its wr_en bit high loads d at the clock edge. Several strobes may be high together; all selected registers load the same d.
- G load by g_mode:
  - 0/3: G ← d
  - 1 (shift right): G ← {wl_hi_in, d[WIDTH-1:1]}
  - 2 (cycle left): G ← {d[WIDTH-2:0], wl_lo_in}
- X/Y: when clr_xy and a load are both asserted in the same cycle, the load wins, so a clear-then-write takes one cycle. clr_xy alone zeroes both registers.
- Adder: ones'-complement slice arithmetic is unsigned add with carry. The parent closes the EAC loop only through eac_q, never combinationally.
- EAC (top only):
  - eac_cap: eac_q ← co.
  - clr_xy without eac_cap: eac_q ← 0.
  - Neither asserted: eac_q holds.
- Overflow (top only, WIDTH≥2): when wr_en[A] & wr_src, compare sum[W-1:W-2]:
  - 01 → set ovf_pos
  - 10 → set ovf_neg
  - Flags are sticky until ovf_clr. ovf_clr in the same cycle as a set: the set wins.
- rd_out is combinational from current state and rd_sel.

## Timing
- Register write: data visible on rd_out one cycle after the strobe.
- sum/co: zero-cycle combinational from X, Y, ci. X/Y loads are reflected the cycle after the load.
- Two-pass EAC add, cycle by cycle:
  - cycle n: eac_cap, co captured.
  - cycle n+1: parent drives ci=eac_q.
  - end of cycle n+1: A written from sum.
- Reset asserted mid-sequence clears all state immediately. Deassertion is synchronised by the parent.

## Structure
- Shared package agc_arith_pkg:
  - rd_sel encodings (RD_NONE..RD_SUM)
  - wr_en bit indices (WR_A..WR_G)
  - g_mode encodings
- One sub-module agc_slice_adder (WIDTH-bit add with ci/co), reused by the wrapper's carry chain.
- IS_TOP logic goes in a generate block.

## Test plan
- WIDTH=4. Reset, then wl_in=4'hA, wr_en=A|Q. Next cycle rd_sel=A → A; rd_sel=Q → A; g_par=0.
- X←4'h9, Y←4'h8, ci=1 → sum=4'h2, co=1. Same, eac_cap → eac_q=1 next cycle.
- g_mode=1, wl_in=4'b0110, wl_hi_in=1 → G=4'b1011. g_mode=2, wl_in=4'b0110, wl_lo_in=1 → G=4'b1101.
- IS_TOP=1: X=4'b0100, Y=4'b0100, ci=0, wr_en=A, wr_src=1 → A=4'b1000, ovf_neg=1 after one cycle. The flag holds over 3 idle cycles; ovf_clr → 0.
- clr_xy with x_load (wl_in=4'h5) → X=5, Y=0. clr_xy alone → X=0.
- Assert rst while X=4'hF and ovf_pos=1 → all outputs 0 asynchronously, before the next clk edge.
